spi_reg_responder: RTL and testbench

- SPI mode-0 responder (slave end) that fronts an 8-bit-wide register bank for the SPI master in the same subsystem.
- Oversamples sclk/ss/mosi in the system clock domain, decodes a 3-byte frame (opcode, address, data), and performs a register write or drives read data on miso.
- Exposes the bank to local logic through a parallel read port, plus a done pulse per completed frame.

---
 rtl/spi_resp_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_reg_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_reg_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared constants and FSM encoding for the SPI register responder.
package spi_resp_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] OP_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] OP_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ADDR,
    ST_DATA,
    ST_WAIT_SS
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous input with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder fronting an 8-bit register bank (3-byte frames: opcode, address, data).
// Optional `SPI_RESP_IRQ_EN adds an irq output set by writes and cleared by reading the top address.
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [BYTE_W-1:0] loc_rdata,
  output logic              frame_done,
`ifdef SPI_RESP_IRQ_EN
  output logic              irq,
`endif
  output logic              frame_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_rise, ss_fall, ss_lvl;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clock (clock), .reset (reset), .d_i (sclk),
    .q_o (sclk_lvl_unused), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );

  // ss idles high, so its synchronizer resets high to avoid a false frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clock (clock), .reset (reset), .d_i (ss),
    .q_o (ss_lvl), .rise_o (ss_rise), .fall_o (ss_fall)
  );

  always_ff @(posedge clock) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_q, rx_d, tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_read_q, is_read_d;
  logic                done_q, done_d, err_q, err_d;
  logic                bank_we;
  logic [BYTE_W-1:0]   bank_q [DEPTH];
  logic [BYTE_W-1:0]   rx_next, rd_value;
  logic [ADDR_W-1:0]   rx_addr;
  logic                byte_done;

  assign rx_next   = {rx_q[BYTE_W-2:0], mosi_s};
  assign rx_addr   = rx_next[ADDR_W-1:0];
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

`ifdef SPI_RESP_IRQ_EN
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  logic irq_q, irq_d;

  always_ff @(posedge clock) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq      = irq_q;
  assign rd_value = (rx_addr == TOP_ADDR) ? {{(BYTE_W-1){1'b0}}, irq_q} : bank_q[rx_addr];
`else
  assign rd_value = bank_q[rx_addr];
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bank_we   = 1'b0;
`ifdef SPI_RESP_IRQ_EN
    irq_d     = irq_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d   = ST_OPCODE;
          bit_cnt_d = '0;
        end
      end
      ST_OPCODE, ST_ADDR, ST_DATA: begin
        if (sclk_rise) begin
          rx_d      = rx_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // The fall right after the address byte must keep the MSB already on miso.
        if (state_q == ST_DATA && is_read_q && sclk_fall && bit_cnt_q != 3'd0)
          tx_d = {tx_q[BYTE_W-2:0], 1'b0};
        if (byte_done) begin
          if (state_q == ST_OPCODE) begin
            if (rx_next == OP_WRITE || rx_next == OP_READ) begin
              is_read_d = (rx_next == OP_READ);
              state_d   = ST_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = ST_WAIT_SS;
            end
          end else if (state_q == ST_ADDR) begin
            addr_d  = rx_addr;
            tx_d    = rd_value;
            state_d = ST_DATA;
          end else begin
            done_d  = 1'b1;
            bank_we = !is_read_q;
            state_d = ST_WAIT_SS;
`ifdef SPI_RESP_IRQ_EN
            if (!is_read_q)                irq_d = 1'b1;
            else if (addr_q == TOP_ADDR)   irq_d = 1'b0;
`endif
          end
        end
        // A completing data byte beats a simultaneous ss release.
        if (ss_rise) begin
          state_d = ST_IDLE;
          if (!(byte_done && state_q == ST_DATA)) err_d = 1'b1;
        end
      end
      ST_WAIT_SS: begin
        if (ss_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      is_read_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      is_read_q <= is_read_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the bank must read 00 after reset, so it is a resettable flop array rather than a RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (bank_we) begin
      bank_q[addr_q] <= rx_next;
    end
  end

  assign loc_rdata  = bank_q[loc_addr];
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign miso       = (state_q == ST_DATA && is_read_q && !ss_lvl) ? tx_q[BYTE_W-1] : 1'b0;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomized bench for spi_reg_responder against a frame-level model with per-cycle output checks.
module tb_spi_reg_responder;

  localparam int ADDR_W = 4;
  localparam int SYNC   = 2;
  localparam int HALF   = 8;
  localparam int DEPTH  = 16;

  logic clock = 1'b0;
  logic reset, ss, sclk, mosi, miso, frame_done, frame_err;
  logic [ADDR_W-1:0] loc_addr;
  logic [7:0] loc_rdata;
`ifdef SPI_RESP_IRQ_EN
  logic irq;
`endif

  spi_reg_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
    .clock      (clock),
    .reset      (reset),
    .ss         (ss),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .loc_addr   (loc_addr),
    .loc_rdata  (loc_rdata),
    .frame_done (frame_done),
`ifdef SPI_RESP_IRQ_EN
    .irq        (irq),
`endif
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events keyed by the cycle in which the DUT output must show them.
  typedef struct packed {
    bit       done;
    bit       err;
    bit       we;
    bit [3:0] addr;
    bit [7:0] data;
    bit       iset;
    bit       iclr;
  } ev_t;

  ev_t    ev [int];
  ev_t    cur_ev;
  bit [7:0] m_bank [DEPTH];
  bit     m_irq = 1'b0;
  bit     chk_en = 1'b0;
  int     rw_start = 0;
  int     rw_end = 0;
  int     n_done = 0;
  int     n_err = 0;

  function automatic ev_t get_ev(input int k);
    ev_t e;
    e = '0;
    if (ev.exists(k)) e = ev[k];
    return e;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      cur_ev = '0;
      if (ev.exists(cyc)) begin
        cur_ev = ev[cyc];
        ev.delete(cyc);
      end
      if (cur_ev.we)   m_bank[cur_ev.addr] = cur_ev.data;
      if (cur_ev.iset) m_irq = 1'b1;
      if (cur_ev.iclr) m_irq = 1'b0;
      check("frame_done", {7'b0, frame_done}, {7'b0, cur_ev.done});
      check("frame_err",  {7'b0, frame_err},  {7'b0, cur_ev.err});
      check("loc_rdata",  loc_rdata, m_bank[loc_addr]);
      if (!(cyc >= rw_start && cyc < rw_end)) check("miso_idle", {7'b0, miso}, 8'h00);
`ifdef SPI_RESP_IRQ_EN
      check("irq", {7'b0, irq}, {7'b0, m_irq});
`endif
      if (frame_done === 1'b1) n_done++;
      if (frame_err === 1'b1)  n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
      loc_addr = 4'($urandom);
    end
  endtask

  task automatic peek(input string name, input logic [3:0] a, input logic [7:0] exp);
    loc_addr = a;
    #1;
    check(name, loc_rdata, exp);
  endtask

  // Drives one frame as a mode-0 master; schedules the model's expected pulses.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nbits, input bit ss_last, input bit abort,
                           output logic [7:0] rd);
    logic [23:0] fr;
    logic [7:0]  exp_rd;
    logic [3:0]  a;
    bit          valid, is_rd;
    int          c;
    ev_t         e;
    fr     = {b0, b1, b2};
    valid  = (b0 == 8'h02) || (b0 == 8'h03);
    is_rd  = (b0 == 8'h03);
    a      = b1[3:0];
    exp_rd = m_bank[a];
`ifdef SPI_RESP_IRQ_EN
    if (a == 4'hF) exp_rd = {7'b0, m_irq};
`endif
    rd = '0;
    ss = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = fr[23-i];
      tick(HALF);
      if (valid && is_rd && i >= 16) begin
        rd = {rd[6:0], miso};
        check("miso_bit", {7'b0, miso}, {7'b0, exp_rd[23-i]});
      end
      sclk = 1'b1;
      if (ss_last && i == nbits - 1) ss = 1'b1;
      c = cyc + SYNC + 1;
      if (i == 7 && !valid) begin
        e = get_ev(c); e.err = 1'b1; ev[c] = e;
      end
      if (i == 15 && valid && is_rd) begin
        rw_start = c;
        rw_end   = 32'h7fff_ffff;
      end
      if (i == 23 && valid) begin
        e = get_ev(c);
        e.done = 1'b1;
        if (is_rd) begin
          rw_end = c;
`ifdef SPI_RESP_IRQ_EN
          if (a == 4'hF) e.iclr = 1'b1;
`endif
        end else begin
          e.we = 1'b1; e.addr = a; e.data = b2;
`ifdef SPI_RESP_IRQ_EN
          e.iset = 1'b1;
`endif
        end
        ev[c] = e;
      end
      tick(HALF);
      sclk = 1'b0;
    end
    if (abort) return;
    tick(HALF);
    if (!ss_last) begin
      ss = 1'b1;
      if (nbits < 8 || (valid && nbits < 24)) begin
        c = cyc + SYNC + 1;
        e = get_ev(c); e.err = 1'b1; ev[c] = e;
      end
    end
    tick(2 * HALF);
  endtask

  logic [7:0] rd;
  int d0, e0;
  logic [7:0] b0, b1, b2;
  int kind, nb;
  bit sl;

  initial begin
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; loc_addr = '0;
    tick(3);
    check("rst_miso", {7'b0, miso}, 8'h00);
    check("rst_done", {7'b0, frame_done}, 8'h00);
    check("rst_err",  {7'b0, frame_err}, 8'h00);
    peek("rst_bank0", 4'h0, 8'h00);
    peek("rst_bankF", 4'hF, 8'h00);
    reset = 1'b0;
    chk_en = 1'b1;
    tick(4);

    d0 = n_done; e0 = n_err;
    spi_frame(8'h02, 8'h05, 8'hA5, 24, 1'b0, 1'b0, rd);
    check("wr_done_cnt", 8'(n_done - d0), 8'd1);
    check("wr_err_cnt",  8'(n_err - e0),  8'd0);
    peek("wr_bank5", 4'h5, 8'hA5);

    d0 = n_done;
    spi_frame(8'h03, 8'h05, 8'h00, 24, 1'b0, 1'b0, rd);
    check("rd_byte", rd, 8'hA5);
    check("rd_done_cnt", 8'(n_done - d0), 8'd1);

    d0 = n_done; e0 = n_err;
    spi_frame(8'h7F, 8'h05, 8'h11, 24, 1'b0, 1'b0, rd);
    check("badop_err_cnt",  8'(n_err - e0),  8'd1);
    check("badop_done_cnt", 8'(n_done - d0), 8'd0);
    peek("badop_bank5", 4'h5, 8'hA5);

    spi_frame(8'h02, 8'hF3, 8'h3C, 24, 1'b0, 1'b0, rd);
    peek("alias_bank3", 4'h3, 8'h3C);

    e0 = n_err;
    spi_frame(8'h02, 8'h03, 8'h99, 12, 1'b0, 1'b0, rd);
    check("trunc_err_cnt", 8'(n_err - e0), 8'd1);
    peek("trunc_bank3", 4'h3, 8'h3C);

    d0 = n_done; e0 = n_err;
    spi_frame(8'h02, 8'h03, 8'h5A, 24, 1'b1, 1'b0, rd);
    check("sslast_done_cnt", 8'(n_done - d0), 8'd1);
    check("sslast_err_cnt",  8'(n_err - e0),  8'd0);
    peek("sslast_bank3", 4'h3, 8'h5A);

    spi_frame(8'h03, 8'hF3, 8'h00, 24, 1'b0, 1'b0, rd);
    check("alias_rd", rd, 8'h5A);

`ifdef SPI_RESP_IRQ_EN
    spi_frame(8'h03, 8'h0F, 8'h00, 24, 1'b0, 1'b0, rd);
    check("irq_rd_set", rd, 8'h01);
    check("irq_cleared", {7'b0, irq}, 8'h00);
    spi_frame(8'h03, 8'h0F, 8'h00, 24, 1'b0, 1'b0, rd);
    check("irq_rd_clr", rd, 8'h00);
`else
    spi_frame(8'h02, 8'h0F, 8'hC3, 24, 1'b0, 1'b0, rd);
    spi_frame(8'h03, 8'h0F, 8'h00, 24, 1'b0, 1'b0, rd);
    check("top_rd", rd, 8'hC3);
`endif

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      if (kind < 4)      b0 = 8'h02;
      else if (kind < 8) b0 = 8'h03;
      else begin
        b0 = 8'($urandom);
        if (b0 == 8'h02 || b0 == 8'h03) b0 = 8'h7F;
      end
      nb = 24;
      sl = ($urandom_range(0, 3) == 0);
      if (b0 == 8'h02 && $urandom_range(0, 4) == 0) begin
        nb = $urandom_range(1, 23);
        sl = 1'b0;
      end
      spi_frame(b0, b1, b2, nb, sl, 1'b0, rd);
    end

    // Reset in the middle of a write's data byte.
    d0 = n_done; e0 = n_err;
    spi_frame(8'h02, 8'h07, 8'hEE, 20, 1'b0, 1'b1, rd);
    chk_en = 1'b0;
    reset = 1'b1; ss = 1'b1; sclk = 1'b0;
    tick(4);
    for (int i = 0; i < DEPTH; i++) m_bank[i] = '0;
    m_irq = 1'b0;
    ev.delete();
    rw_start = 0; rw_end = 0;
    reset = 1'b0;
    chk_en = 1'b1;
    tick(40);
    check("rstmid_done_cnt", 8'(n_done - d0), 8'd0);
    check("rstmid_err_cnt",  8'(n_err - e0),  8'd0);
    peek("rstmid_bank7", 4'h7, 8'h00);
    peek("rstmid_bank3", 4'h3, 8'h00);
    spi_frame(8'h02, 8'h07, 8'hEE, 24, 1'b0, 1'b0, rd);
    peek("post_rst_bank7", 4'h7, 8'hEE);

    tick(4);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
